// File: rtl/pong_game_logic.sv
// Frame-stepped Pong core: two paddles, one ball, scoring and serve/over sequencing.
// Build option: define PONG_SPEEDUP_EN to speed the ball up on every paddle hit.
//
// state | meaning
// IDLE  | after reset, waiting for btn_serve
// SERVE | ball parked at centre, 60-tick countdown
// PLAY  | ball in motion, walls/paddles/misses evaluated each tick
// OVER  | a player reached WIN_SCORE, waiting for btn_serve
module pong_game_logic #(
    parameter int PADDLE_STEP = 4,
    parameter int BALL_SPEED  = 2,
    parameter int WIN_SCORE   = 9,
    parameter int SPEED_MAX   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    input  logic       btn_serve,
    output logic [9:0] paddle_left_pos,
    output logic [9:0] paddle_right_pos,
    output logic [9:0] ball_pos_x,
    output logic [9:0] ball_pos_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] state,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

    localparam int SPEED_TOP = (SPEED_MAX > BALL_SPEED) ? SPEED_MAX : BALL_SPEED;
    localparam int SPEED_W   = $clog2(SPEED_TOP + 1);

    localparam logic [9:0] PADDLE_HOME = 10'd215;
    localparam logic [9:0] PADDLE_MAX  = 10'd430;
    localparam logic [9:0] BALL_X0     = 10'd315;
    localparam logic [9:0] BALL_Y0     = 10'd235;
    localparam logic [5:0] SERVE_LOAD  = 6'd59;

    state_t               state_q, state_d;
    logic [9:0]           pl_q, pl_d, pr_q, pr_d;
    logic [9:0]           bx_q, bx_d, by_q, by_d;
    logic [3:0]           sl_q, sl_d, sr_q, sr_d;
    logic                 dx_q, dx_d, dy_q, dy_d;
    logic [SPEED_W-1:0]   spd_q, spd_d;
    logic [5:0]           cnt_q, cnt_d;
    logic                 go_q;

    logic signed [10:0]   step, nx, ny;
    logic                 l_ovl, r_ovl;

    function automatic logic [9:0] move_paddle(input logic [9:0] pos, input logic up,
                                               input logic dn);
        logic [10:0] p;
        p = {1'b0, pos};
        move_paddle = pos;
        if (up && !dn)
            move_paddle = (p < 11'(PADDLE_STEP)) ? 10'd0 : 10'(p - 11'(PADDLE_STEP));
        else if (dn && !up)
            move_paddle = ((p + 11'(PADDLE_STEP)) > {1'b0, PADDLE_MAX}) ? PADDLE_MAX
                                                                     : 10'(p + 11'(PADDLE_STEP));
    endfunction

    function automatic logic [SPEED_W-1:0] bumped(input logic [SPEED_W-1:0] s);
`ifdef PONG_SPEEDUP_EN
        bumped = (s >= SPEED_W'(SPEED_MAX)) ? s : s + 1'b1;
`else
        bumped = s;
`endif
    endfunction

    // Signed 11-bit candidates so a step past either edge is visible before clamping.
    assign step  = $signed(11'(spd_q));
    assign nx    = $signed({1'b0, bx_q}) + (dx_q ? step : -step);
    assign ny    = $signed({1'b0, by_q}) + (dy_q ? step : -step);
    assign l_ovl = (({1'b0, by_q} + 11'd10) > {1'b0, pl_q}) && ({1'b0, by_q} < ({1'b0, pl_q} + 11'd50));
    assign r_ovl = (({1'b0, by_q} + 11'd10) > {1'b0, pr_q}) && ({1'b0, by_q} < ({1'b0, pr_q} + 11'd50));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pl_q    <= PADDLE_HOME;
            pr_q    <= PADDLE_HOME;
            bx_q    <= BALL_X0;
            by_q    <= BALL_Y0;
            sl_q    <= 4'd0;
            sr_q    <= 4'd0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            spd_q   <= SPEED_W'(BALL_SPEED);
            cnt_q   <= 6'd0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            spd_q   <= spd_d;
            cnt_q   <= cnt_d;
            go_q    <= (state_d == OVER);
        end
    end

    always_comb begin
        state_d = state_q;
        pl_d    = pl_q;
        pr_d    = pr_q;
        bx_d    = bx_q;
        by_d    = by_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        spd_d   = spd_q;
        cnt_d   = cnt_q;
        if (frame_tick) begin
            if (state_q == SERVE || state_q == PLAY) begin
                pl_d = move_paddle(pl_q, btn_l_up, btn_l_dn);
                pr_d = move_paddle(pr_q, btn_r_up, btn_r_dn);
            end
            unique case (state_q)
                IDLE: begin
                    if (btn_serve) begin
                        state_d = SERVE;
                        cnt_d   = SERVE_LOAD;
                        spd_d   = SPEED_W'(BALL_SPEED);
                    end
                end
                SERVE: begin
                    bx_d = BALL_X0;
                    by_d = BALL_Y0;
                    if (cnt_q == 6'd0) state_d = PLAY;
                    else               cnt_d   = cnt_q - 6'd1;
                end
                PLAY: begin
                    if (ny <= 11'sd0) begin
                        by_d = 10'd0;
                        dy_d = 1'b1;
                    end else if (ny >= 11'sd470) begin
                        by_d = 10'd470;
                        dy_d = 1'b0;
                    end else begin
                        by_d = ny[9:0];
                    end
                    // Hits take priority over misses; a miss keeps dx, which already faces the loser.
                    if (!dx_q && nx <= 11'sd15 && l_ovl) begin
                        bx_d  = 10'd16;
                        dx_d  = 1'b1;
                        spd_d = bumped(spd_q);
                    end else if (dx_q && (nx + 11'sd10) >= 11'sd620 && r_ovl) begin
                        bx_d  = 10'd610;
                        dx_d  = 1'b0;
                        spd_d = bumped(spd_q);
                    end else if (!dx_q && nx <= 11'sd0) begin
                        sr_d    = sr_q + 4'd1;
                        bx_d    = BALL_X0;
                        by_d    = BALL_Y0;
                        cnt_d   = SERVE_LOAD;
                        spd_d   = SPEED_W'(BALL_SPEED);
                        state_d = (sr_d == 4'(WIN_SCORE)) ? OVER : SERVE;
                    end else if (dx_q && nx >= 11'sd630) begin
                        sl_d    = sl_q + 4'd1;
                        bx_d    = BALL_X0;
                        by_d    = BALL_Y0;
                        cnt_d   = SERVE_LOAD;
                        spd_d   = SPEED_W'(BALL_SPEED);
                        state_d = (sl_d == 4'(WIN_SCORE)) ? OVER : SERVE;
                    end else begin
                        bx_d = nx[9:0];
                    end
                end
                OVER: begin
                    if (btn_serve) begin
                        sl_d    = 4'd0;
                        sr_d    = 4'd0;
                        pl_d    = PADDLE_HOME;
                        pr_d    = PADDLE_HOME;
                        bx_d    = BALL_X0;
                        by_d    = BALL_Y0;
                        cnt_d   = SERVE_LOAD;
                        spd_d   = SPEED_W'(BALL_SPEED);
                        state_d = SERVE;
                    end
                end
            endcase
        end
    end

    assign paddle_left_pos  = pl_q;
    assign paddle_right_pos = pr_q;
    assign ball_pos_x       = bx_q;
    assign ball_pos_y       = by_q;
    assign score_left       = sl_q;
    assign score_right      = sr_q;
    assign state            = state_q;
    assign game_over        = go_q;

endmodule
